// File: rtl/rx_pattern_checker_pkg.sv
// Shared types and constants for the loopback pattern checker.
// Holds the lock FSM states, the default pattern bytes and the index/run widths.
package rx_pattern_checker_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [7:0] DEF_PAT0 = 8'hF0;
    localparam logic [7:0] DEF_PAT1 = 8'h0F;
    localparam logic [7:0] DEF_PAT2 = 8'h3C;

    localparam int EXP_W = 2;
    localparam int RUN_W = 4;

    // The expected index walks 0 -> 1 -> 2 -> 0.
    function automatic logic [EXP_W-1:0] exp_next(input logic [EXP_W-1:0] e);
        return (e == EXP_W'(2)) ? '0 : e + EXP_W'(1);
    endfunction

endpackage

// File: rtl/rx_pattern_checker_sat_counter.sv
// Saturating up-counter with a synchronous clear that dominates the increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/rx_pattern_checker.sv
// Locks onto the cyclic byte sequence PAT0 -> PAT1 -> PAT2 and keeps
// mismatch / byte statistics while locked.
module rx_pattern_checker
    import rx_pattern_checker_pkg::*;
#(
    parameter logic [7:0] PAT0     = DEF_PAT0,
    parameter logic [7:0] PAT1     = DEF_PAT1,
    parameter logic [7:0] PAT2     = DEF_PAT2,
    parameter int         LOCK_CNT = 3,
    parameter int         LOSS_CNT = 2,
    parameter int         CNT_W    = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [7:0]       data_i,
    input  logic             valid_i,
    input  logic             clear_i,
    output logic             locked_o,
    output logic             err_pulse_o,
    output logic [CNT_W-1:0] err_cnt_o,
    output logic [CNT_W-1:0] byte_cnt_o,
    output logic [7:0]       last_bad_o
);

    localparam logic [RUN_W-1:0] LOCK_TH = RUN_W'(LOCK_CNT);
    localparam logic [RUN_W-1:0] LOSS_TH = RUN_W'(LOSS_CNT);

    state_t             state, state_nxt;
    logic [EXP_W-1:0]   exp_idx, exp_nxt;
    logic [RUN_W-1:0]   good_run, good_nxt, good_inc;
    logic [RUN_W-1:0]   bad_run, bad_nxt, bad_inc;
    logic [7:0]         exp_byte;
    logic               match;
    logic               err_inc;
    logic               byte_inc;

    assign good_inc = good_run + RUN_W'(1);
    assign bad_inc  = bad_run + RUN_W'(1);

    always_comb begin
        exp_byte = PAT2;
        case (exp_idx)
            EXP_W'(0): exp_byte = PAT0;
            EXP_W'(1): exp_byte = PAT1;
            default:   exp_byte = PAT2;
        endcase
    end

    assign match = (data_i == exp_byte);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= HUNT;
            exp_idx  <= '0;
            good_run <= '0;
            bad_run  <= '0;
        end else begin
            state    <= state_nxt;
            exp_idx  <= exp_nxt;
            good_run <= good_nxt;
            bad_run  <= bad_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        exp_nxt   = exp_idx;
        good_nxt  = good_run;
        bad_nxt   = bad_run;
        err_inc   = 1'b0;
        byte_inc  = 1'b0;
        if (valid_i) begin
            case (state)
                HUNT: begin
                    // Seeding priority is PAT0 > PAT1 > PAT2 when pattern bytes coincide.
                    if (data_i == PAT0 || data_i == PAT1 || data_i == PAT2) begin
                        good_nxt  = RUN_W'(1);
                        bad_nxt   = '0;
                        state_nxt = (LOCK_CNT == 1) ? LOCKED : VERIFY;
                        if (data_i == PAT0) begin
                            exp_nxt = EXP_W'(1);
                        end else if (data_i == PAT1) begin
                            exp_nxt = EXP_W'(2);
                        end else begin
                            exp_nxt = EXP_W'(0);
                        end
                    end
                end
                VERIFY: begin
                    if (match) begin
                        good_nxt = good_inc;
                        exp_nxt  = exp_next(exp_idx);
                        if (good_inc >= LOCK_TH) begin
                            state_nxt = LOCKED;
                            bad_nxt   = '0;
                        end
                    end else begin
                        state_nxt = HUNT;
                    end
                end
                LOCKED: begin
                    byte_inc = 1'b1;
                    exp_nxt  = exp_next(exp_idx);
                    if (match) begin
                        bad_nxt = '0;
                    end else begin
                        err_inc = 1'b1;
                        bad_nxt = bad_inc;
                        if (bad_inc >= LOSS_TH) begin
                            state_nxt = HUNT;
                        end
                    end
                end
                default: begin
                    state_nxt = HUNT;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_pulse_o <= 1'b0;
            last_bad_o  <= '0;
        end else begin
            err_pulse_o <= err_inc;
            if (clear_i) begin
                last_bad_o <= '0;
            end else if (err_inc) begin
                last_bad_o <= data_i;
            end
        end
    end

    assign locked_o = (state == LOCKED);

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk   (clk_i),
        .rst   (rst_i),
        .inc   (err_inc),
        .clr   (clear_i),
        .count (err_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_byte_cnt (
        .clk   (clk_i),
        .rst   (rst_i),
        .inc   (byte_inc),
        .clr   (clear_i),
        .count (byte_cnt_o)
    );

endmodule

// File: tb/tb_rx_pattern_checker.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// behavioural lock/statistics model; narrow counters exercise saturation.
module tb_rx_pattern_checker;

    localparam int CNT_W    = 4;
    localparam int LOCK_CNT = 3;
    localparam int LOSS_CNT = 2;
    localparam int MAXC     = (1 << CNT_W) - 1;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic [7:0]       data_i;
    logic             valid_i;
    logic             clear_i;
    logic             locked_o;
    logic             err_pulse_o;
    logic [CNT_W-1:0] err_cnt_o;
    logic [CNT_W-1:0] byte_cnt_o;
    logic [7:0]       last_bad_o;

    int checks   = 0;
    int failures = 0;

    int pats [3] = '{8'hF0, 8'h0F, 8'h3C};

    // Model: 0 = hunting, 1 = verifying, 2 = locked.
    int m_state, m_exp, m_good, m_bad, m_err, m_byte, m_last, m_pulse;

    rx_pattern_checker #(
        .LOCK_CNT (LOCK_CNT),
        .LOSS_CNT (LOSS_CNT),
        .CNT_W    (CNT_W)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .data_i      (data_i),
        .valid_i     (valid_i),
        .clear_i     (clear_i),
        .locked_o    (locked_o),
        .err_pulse_o (err_pulse_o),
        .err_cnt_o   (err_cnt_o),
        .byte_cnt_o  (byte_cnt_o),
        .last_bad_o  (last_bad_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkValue(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        m_state = 0; m_exp = 0; m_good = 0; m_bad = 0;
        m_err = 0; m_byte = 0; m_last = 0; m_pulse = 0;
    endtask

    task automatic modelStep(input int d, input bit v, input bit c);
        int k;
        m_pulse = 0;
        if (v) begin
            if (m_state == 0) begin
                k = -1;
                for (int i = 0; i < 3; i++) if (k < 0 && d == pats[i]) k = i;
                if (k >= 0) begin
                    m_exp   = (k + 1) % 3;
                    m_good  = 1;
                    m_bad   = 0;
                    m_state = (LOCK_CNT == 1) ? 2 : 1;
                end
            end else if (m_state == 1) begin
                if (d == pats[m_exp]) begin
                    m_good++;
                    m_exp = (m_exp + 1) % 3;
                    if (m_good >= LOCK_CNT) begin
                        m_state = 2;
                        m_bad   = 0;
                    end
                end else begin
                    m_state = 0;
                end
            end else begin
                if (m_byte < MAXC) m_byte++;
                if (d == pats[m_exp]) begin
                    m_bad = 0;
                end else begin
                    if (m_err < MAXC) m_err++;
                    m_last  = d;
                    m_pulse = 1;
                    m_bad++;
                    if (m_bad >= LOSS_CNT) m_state = 0;
                end
                m_exp = (m_exp + 1) % 3;
            end
        end
        if (c) begin
            m_err  = 0;
            m_byte = 0;
            m_last = 0;
        end
    endtask

    task automatic checkOutput();
        checkValue("locked",    int'(locked_o),    (m_state == 2) ? 1 : 0);
        checkValue("err_pulse", int'(err_pulse_o), m_pulse);
        checkValue("err_cnt",   int'(err_cnt_o),   m_err);
        checkValue("byte_cnt",  int'(byte_cnt_o),  m_byte);
        checkValue("last_bad",  int'(last_bad_o),  m_last);
    endtask

    task automatic applyStimulus(input int d, input bit v, input bit c);
        @(negedge clk_i);
        data_i  = d[7:0];
        valid_i = v;
        clear_i = c;
        @(posedge clk_i);
        modelStep(d, v, c);
        #1;
        checkOutput();
    endtask

    task automatic send(input int d);
        applyStimulus(d, 1'b1, 1'b0);
    endtask

    // Reset lands between clock edges; outputs must clear before the next edge.
    task automatic asyncReset();
        @(negedge clk_i);
        valid_i = 1'b0;
        clear_i = 1'b0;
        #2;
        rst_i = 1'b1;
        #1;
        modelReset();
        checkValue("rst_locked",   int'(locked_o),    0);
        checkValue("rst_err_cnt",  int'(err_cnt_o),   0);
        checkValue("rst_byte_cnt", int'(byte_cnt_o),  0);
        checkValue("rst_last_bad", int'(last_bad_o),  0);
        checkValue("rst_pulse",    int'(err_pulse_o), 0);
        #1;
        rst_i = 1'b0;
    endtask

    initial begin
        int g;
        int sel;
        int d;
        bit v;
        bit c;

        rst_i   = 1'b1;
        data_i  = 8'h00;
        valid_i = 1'b0;
        clear_i = 1'b0;
        modelReset();
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        checkOutput();

        send(8'hF0); send(8'h0F);
        checkValue("pre_lock", int'(locked_o), 0);
        send(8'h3C);
        checkValue("lock_after_3", int'(locked_o), 1);
        send(8'hF0);
        checkValue("byte_cnt_first", int'(byte_cnt_o), 1);
        checkValue("err_cnt_clean", int'(err_cnt_o), 0);

        send(8'h55);
        checkValue("single_err_pulse", int'(err_pulse_o), 1);
        checkValue("single_err_cnt", int'(err_cnt_o), 1);
        checkValue("single_last_bad", int'(last_bad_o), 8'h55);
        checkValue("single_still_locked", int'(locked_o), 1);
        send(8'h3C);
        checkValue("pulse_one_cycle", int'(err_pulse_o), 0);
        checkValue("byte_cnt_three", int'(byte_cnt_o), 3);

        applyStimulus(8'h00, 1'b0, 1'b1);
        send(8'hF0); send(8'hAA);
        checkValue("one_bad_locked", int'(locked_o), 1);
        send(8'hBB);
        checkValue("two_bad_err_cnt", int'(err_cnt_o), 2);
        checkValue("two_bad_unlock", int'(locked_o), 0);
        send(8'h0F); send(8'h3C); send(8'hF0);
        checkValue("relock", int'(locked_o), 1);

        send(8'h11); send(8'h22);
        send(8'hF0); send(8'h3C);
        checkValue("verify_abort", int'(locked_o), 0);
        send(8'hF0); applyStimulus(8'h77, 1'b0, 1'b0);
        send(8'h0F); applyStimulus(8'h99, 1'b0, 1'b0);
        checkValue("gap_not_yet", int'(locked_o), 0);
        send(8'h3C);
        checkValue("gap_lock", int'(locked_o), 1);

        applyStimulus(8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) send(pats[i % 3]);
        checkValue("byte_cnt_sat", int'(byte_cnt_o), 15);
        applyStimulus(8'h3C, 1'b1, 1'b1);
        checkValue("clear_wins", int'(byte_cnt_o), 0);
        checkValue("clear_keeps_lock", int'(locked_o), 1);

        asyncReset();
        send(8'hF0); send(8'h0F);
        checkValue("post_rst_no_lock", int'(locked_o), 0);
        send(8'h3C);
        checkValue("post_rst_lock", int'(locked_o), 1);

        g = 0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 999) < 3) begin
                asyncReset();
            end else begin
                v   = ($urandom_range(0, 9) < 8);
                c   = ($urandom_range(0, 39) == 0);
                sel = $urandom_range(0, 19);
                if (sel < 16)      d = pats[g];
                else if (sel < 18) d = pats[$urandom_range(0, 2)];
                else               d = $urandom_range(0, 255);
                if (sel == 19) g = $urandom_range(0, 2);
                if (v) g = (g + 1) % 3;
                applyStimulus(d, v, c);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
